uart_word_tx: RTL and testbench

//  UART transmitter that serialises one 32-bit memory word as NBYTES 8N1 frames.

---
 rtl/uart_word_tx.sv | 123 ++++++++++++
 tb/tb_uart_word_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// UART transmitter that sends one 32-bit word as NBYTES back-to-back 8N1 frames,
// least significant byte first, with per-byte and per-word completion pulses.
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NBYTES       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_word,
  output logic        o_ready,
  output logic        o_tx_serial,
  output logic        o_tx_active,
  output logic        o_byte_done,
  output logic        o_word_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0] LAST_BYTE = 2'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t             state;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [2:0]         bit_idx;
  logic [1:0]         byte_idx;
  logic [31:0]        shift_reg;
  logic               tx_reg;
  logic               byte_done_reg;
  logic               word_done_reg;
  logic               baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);

  // The word is shifted right one bit per data bit, so after each byte the
  // next byte is already sitting in the low eight bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      byte_idx      <= '0;
      shift_reg     <= '0;
      tx_reg        <= 1'b1;
      byte_done_reg <= 1'b0;
      word_done_reg <= 1'b0;
    end else begin
      byte_done_reg <= 1'b0;
      word_done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            state     <= START;
            shift_reg <= i_word;
            byte_idx  <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
            tx_reg    <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= DATA;
            tx_reg   <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
              tx_reg  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_reg  <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt      <= '0;
            byte_done_reg <= 1'b1;
            // Next byte starts with no idle gap; the line stays high otherwise.
            if (byte_idx == LAST_BYTE) begin
              state         <= IDLE;
              word_done_reg <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              state    <= START;
              tx_reg   <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          tx_reg <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready     = (state == IDLE);
  assign o_tx_active = (state != IDLE);
  assign o_tx_serial = tx_reg;
  assign o_byte_done = byte_done_reg;
  assign o_word_done = word_done_reg;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: a 4-byte/4-clock instance and a
// 1-byte/2-clock instance, all outputs checked cycle by cycle at negedges.
module tb_uart_word_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_a, valid_b;
  logic [31:0] word_a, word_b;
  logic        ready_a, tx_a, active_a, bdone_a, wdone_a;
  logic        ready_b, tx_b, active_b, bdone_b, wdone_b;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  uart_word_tx #(.CLKS_PER_BIT(4), .NBYTES(4)) dut_a (
    .clk(clk), .reset(reset), .i_valid(valid_a), .i_word(word_a),
    .o_ready(ready_a), .o_tx_serial(tx_a), .o_tx_active(active_a),
    .o_byte_done(bdone_a), .o_word_done(wdone_a)
  );

  uart_word_tx #(.CLKS_PER_BIT(2), .NBYTES(1)) dut_b (
    .clk(clk), .reset(reset), .i_valid(valid_b), .i_word(word_b),
    .o_ready(ready_b), .o_tx_serial(tx_b), .o_tx_active(active_b),
    .o_byte_done(bdone_b), .o_word_done(wdone_b)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected line level m cycles after the accepting edge.
  function automatic logic exp_line(input logic [31:0] w, input int m, input int cpb, input int nb);
    int b;
    int r;
    int bit_n;
    if (m >= nb * 10 * cpb) return 1'b1;
    b     = m / (10 * cpb);
    r     = m % (10 * cpb);
    bit_n = r / cpb;
    if (bit_n == 0) return 1'b0;
    if (bit_n == 9) return 1'b1;
    return w[8 * b + bit_n - 1];
  endfunction

  task automatic check_idle_a(input string tag);
    check_output({tag, "_line"}, tx_a, 1);
    check_output({tag, "_ready"}, ready_a, 1);
    check_output({tag, "_active"}, active_a, 0);
    check_output({tag, "_bdone"}, bdone_a, 0);
    check_output({tag, "_wdone"}, wdone_a, 0);
  endtask

  // Request w at the next edge and check every cycle up to word_done.
  task automatic send_word_a(input logic [31:0] w, input bit hold, input int poke_at);
    valid_a = 1'b1;
    word_a  = w;
    for (int m = 0; m <= 160; m++) begin
      @(negedge clk);
      check_output($sformatf("line_%0d", m), tx_a, exp_line(w, m, 4, 4));
      check_output($sformatf("bdone_%0d", m), bdone_a, (m > 0 && m % 40 == 0));
      check_output($sformatf("wdone_%0d", m), wdone_a, (m == 160));
      check_output($sformatf("ready_%0d", m), ready_a, (m == 160));
      check_output($sformatf("active_%0d", m), active_a, (m != 160));
      if (m == 0) begin
        if (hold) begin
          word_a = 32'hFFFF_FFFF;
        end else begin
          valid_a = 1'b0;
          word_a  = ~w;
        end
      end
      if (m == poke_at) begin
        valid_a = 1'b1;
        word_a  = 32'h1234_5678;
      end
      if (m == poke_at + 1) valid_a = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset   = 1'b0;
    valid_a = 1'b1;
    word_a  = 32'hDEAD_BEEF;
    valid_b = 1'b1;
    word_b  = 32'h0000_00AA;

    $display("[TB] reset held with valid high");
    repeat (5) begin
      @(negedge clk);
      check_idle_a("rst");
      check_output("rst_b_line", tx_b, 1);
      check_output("rst_b_ready", ready_b, 1);
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    reset   = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_idle_a("post_rst");
      check_output("post_rst_b_line", tx_b, 1);
    end

    $display("[TB] word 0xA5C30F81");
    send_word_a(32'hA5C3_0F81, 1'b0, -10);
    @(negedge clk);
    check_idle_a("gap1");

    $display("[TB] back-to-back with held valid");
    send_word_a(32'h0000_0000, 1'b1, -10);
    send_word_a(32'hFFFF_FFFF, 1'b0, -10);
    repeat (3) begin
      @(negedge clk);
      check_idle_a("gap2");
    end

    $display("[TB] reset in the middle of a word");
    valid_a = 1'b1;
    word_a  = 32'h0000_0000;
    for (int m = 0; m <= 50; m++) begin
      @(negedge clk);
      if (m == 0) valid_a = 1'b0;
    end
    check_output("abort_line_before", tx_a, 0);
    #2 reset = 1'b0;
    #1;
    check_output("abort_line_async", tx_a, 1);
    check_output("abort_ready_async", ready_a, 1);
    check_output("abort_active_async", active_a, 0);
    repeat (3) begin
      @(negedge clk);
      check_idle_a("abort_hold");
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle_a("abort_after");
    end
    send_word_a(32'h0000_003C, 1'b0, -10);

    $display("[TB] ignored request while busy");
    send_word_a(32'h5A96_C3E1, 1'b0, 70);
    repeat (8) begin
      @(negedge clk);
      check_idle_a("no_extra");
    end

    $display("[TB] one-byte instance");
    valid_b = 1'b1;
    word_b  = 32'h0000_00FF;
    for (int m = 0; m <= 20; m++) begin
      @(negedge clk);
      if (m == 0) valid_b = 1'b0;
      check_output($sformatf("b_line_%0d", m), tx_b, exp_line(32'h0000_00FF, m, 2, 1));
      check_output($sformatf("b_bdone_%0d", m), bdone_b, (m == 20));
      check_output($sformatf("b_wdone_%0d", m), wdone_b, (m == 20));
      check_output($sformatf("b_ready_%0d", m), ready_b, (m == 20));
      check_output($sformatf("b_active_%0d", m), active_b, (m != 20));
    end
    @(negedge clk);
    check_output("b_idle_line", tx_b, 1);
    check_output("b_idle_bdone", bdone_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
